// File: rtl/eth_tx_arb.sv
// Round-robin, whole-frame transmit arbiter in front of the GMII TX pins.
// Optional per-channel completed-frame counters: define ETH_TX_ARB_STATS_EN.
module eth_tx_arb #(
   parameter int N_CH       = 2,
   parameter int DATA_W     = 8,
   parameter int IFG_CYCLES = 12,
   parameter int START_TO   = 64,
   parameter int MAX_LEN    = 1530
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        i_req,
   input  logic [N_CH*DATA_W-1:0] i_ch_data,
   input  logic [N_CH-1:0]        i_ch_en,
   output logic [N_CH-1:0]        o_gnt,
   output logic [DATA_W-1:0]      o_tx_data,
   output logic                   o_tx_en,
   output logic                   o_busy,
   output logic                   o_timeout,
   output logic                   o_trunc
`ifdef ETH_TX_ARB_STATS_EN
   ,
   input  logic                   i_stats_clr,
   output logic [N_CH*16-1:0]     o_frame_cnt
`endif
);

   localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int WW = $clog2(START_TO) + 1;
   localparam int LW = $clog2(MAX_LEN) + 1;
   localparam int IW = $clog2(IFG_CYCLES + 1) + 1;

   typedef enum logic [1:0] {IDLE, GRANT, XMIT, IFG} state_t;

   state_t              state;
   logic [SW-1:0]       sel;
   logic [SW-1:0]       rr;
   logic [SW-1:0]       nxt;
   logic                found;
   logic [WW-1:0]       wait_cnt;
   logic [LW-1:0]       len_cnt;
   logic [IW-1:0]       ifg_cnt;
   logic                en_s;
   logic [DATA_W-1:0]   data_s;
   logic                active;
   logic                truncating;
   logic                fire;

   // Lowest requester above rr wins; otherwise wrap to the lowest at or below rr.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (i_req[k] && (SW'(k) <= rr)) begin
            nxt   = SW'(k);
            found = 1'b1;
         end
      end
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (i_req[k] && (SW'(k) > rr)) begin
            nxt   = SW'(k);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      en_s   = 1'b0;
      data_s = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel == SW'(k)) begin
            en_s   = i_ch_en[k];
            data_s = i_ch_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign active     = (state == GRANT) || (state == XMIT);
   assign truncating = (state == XMIT) && (len_cnt >= LW'(MAX_LEN));
   assign fire       = active && en_s && !truncating;
   assign o_busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= SW'(N_CH - 1);
         sel       <= '0;
         wait_cnt  <= '0;
         len_cnt   <= '0;
         ifg_cnt   <= '0;
         o_gnt     <= '0;
         o_tx_en   <= 1'b0;
         o_tx_data <= '0;
         o_timeout <= 1'b0;
         o_trunc   <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         o_trunc   <= 1'b0;
         o_tx_en   <= fire;
         o_tx_data <= fire ? data_s : '0;
         case (state)
            IDLE: begin
               if (found) begin
                  sel        <= nxt;
                  rr         <= nxt;
                  o_gnt      <= '0;
                  o_gnt[nxt] <= 1'b1;
                  wait_cnt   <= '0;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (en_s) begin
                  len_cnt <= LW'(1);
                  state   <= XMIT;
               end else if (!i_req[sel]) begin
                  // Nothing went out, so no gap is owed.
                  o_gnt <= '0;
                  state <= IDLE;
               end else if (wait_cnt >= WW'(START_TO - 1)) begin
                  o_gnt     <= '0;
                  o_timeout <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            XMIT: begin
               if (!en_s) begin
                  o_gnt   <= '0;
                  ifg_cnt <= IW'(IFG_CYCLES - 1);
                  state   <= IFG;
               end else if (truncating) begin
                  o_gnt   <= '0;
                  o_trunc <= 1'b1;
                  ifg_cnt <= IW'(IFG_CYCLES - 1);
                  state   <= IFG;
               end else if (len_cnt != '1) begin
                  len_cnt <= len_cnt + 1'b1;
               end
            end
            IFG: begin
               if (ifg_cnt == '0) state <= IDLE;
               else ifg_cnt <= ifg_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ETH_TX_ARB_STATS_EN
   // Counts only frames that ended by the source dropping en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_frame_cnt <= '0;
      end else if (i_stats_clr) begin
         o_frame_cnt <= '0;
      end else if ((state == XMIT) && !en_s) begin
         for (int k = 0; k < N_CH; k++) begin
            if (sel == SW'(k)) o_frame_cnt[k*16 +: 16] <= o_frame_cnt[k*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: byte scoreboard, frame length/gap/owner log.
// Exercises the stats counters only when ETH_TX_ARB_STATS_EN is defined.
module tb_eth_tx_arb;

   localparam int MAX_LEN = 1530;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic        en0, en1;
   logic [7:0]  d0, d1;
   logic [1:0]  o_gnt;
   logic [7:0]  o_tx_data;
   logic        o_tx_en;
   logic        o_busy;
   logic        o_timeout;
   logic        o_trunc;
`ifdef ETH_TX_ARB_STATS_EN
   logic        stats_clr;
   logic [31:0] o_frame_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int first_drive_cyc = 0;
   int trunc_n = 0;
   int tmo_n = 0;

   logic [7:0] exp_q[$];
   int         len_q[$];
   int         gap_q[$];
   int         start_q[$];
   logic [1:0] owner_q[$];

   eth_tx_arb #(
      .N_CH(2), .DATA_W(8), .IFG_CYCLES(12), .START_TO(64), .MAX_LEN(MAX_LEN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_req({req1, req0}),
      .i_ch_data({d1, d0}),
      .i_ch_en({en1, en0}),
      .o_gnt(o_gnt),
      .o_tx_data(o_tx_data),
      .o_tx_en(o_tx_en),
      .o_busy(o_busy),
      .o_timeout(o_timeout),
      .o_trunc(o_trunc)
`ifdef ETH_TX_ARB_STATS_EN
      ,
      .i_stats_clr(stats_clr),
      .o_frame_cnt(o_frame_cnt)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input int ch, input logic en, input logic [7:0] d);
      if (ch == 0) begin
         en0 = en;
         d0  = d;
      end else begin
         en1 = en;
         d1  = d;
      end
   endtask

   task automatic set_req(input int ch, input logic v);
      if (ch == 0) req0 = v;
      else req1 = v;
   endtask

   function automatic logic gnt_of(input int ch);
      return (ch == 0) ? o_gnt[0] : o_gnt[1];
   endfunction

   // Call at a negedge. Source reacts to its grant in the same cycle it sees it.
   task automatic send(input int ch, input int len, input bit drop, input int budget);
      int n;
      logic [7:0] b;
      n = 0;
      while (!gnt_of(ch) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("gnt_wait_ch%0d", ch), 32'(n < budget), 32'd1);
      if (n >= budget) begin
         set_req(ch, 1'b0);
      end else begin
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(1, 255));
            drive(ch, 1'b1, b);
            if (i == 0) begin
               first_drive_cyc = cyc;
               if (drop) set_req(ch, 1'b0);
            end
            if (i < MAX_LEN) exp_q.push_back(b);
            @(negedge clk);
         end
         drive(ch, 1'b0, 8'd0);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (o_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(o_busy), 32'd0);
   endtask

   task automatic do_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      drive(0, 1'b0, 8'd0);
      drive(1, 1'b0, 8'd0);
`ifdef ETH_TX_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(o_gnt), 32'd0);
      check("rst_tx_en", 32'(o_tx_en), 32'd0);
      check("rst_tx_data", 32'(o_tx_data), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_timeout", 32'(o_timeout), 32'd0);
      check("rst_trunc", 32'(o_trunc), 32'd0);
`ifdef ETH_TX_ARB_STATS_EN
      check("rst_frame_cnt", o_frame_cnt, 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      len_q.delete();
      gap_q.delete();
      start_q.delete();
      owner_q.delete();
      trunc_n = 0;
      tmo_n = 0;
   endtask

   // scoreboard / frame monitor
   initial begin
      bit prev_en;
      bit have_end;
      int run;
      int last_end;
      prev_en = 1'b0;
      have_end = 1'b0;
      run = 0;
      last_end = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_en = 1'b0;
            have_end = 1'b0;
            run = 0;
         end else begin
            if (o_tx_en) begin
               if (!prev_en) begin
                  owner_q.push_back(o_gnt);
                  start_q.push_back(cyc);
                  if (have_end) gap_q.push_back(cyc - last_end - 1);
               end
               run++;
               check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) check("sb_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
            end else begin
               check("idle_data", 32'(o_tx_data), 32'd0);
               if (prev_en) begin
                  len_q.push_back(run);
                  run = 0;
                  last_end = cyc - 1;
                  have_end = 1'b1;
               end
            end
            if (o_trunc) trunc_n++;
            if (o_timeout) tmo_n++;
            prev_en = o_tx_en;
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      en0 = 1'b0;
      en1 = 1'b0;
      d0 = 8'd0;
      d1 = 8'd0;
`ifdef ETH_TX_ARB_STATS_EN
      stats_clr = 1'b0;
`endif

      // single 60-byte frame on ch0
      do_reset();
      set_req(0, 1'b1);
      @(negedge clk);
      check("t1_gnt", 32'(o_gnt), 32'd1);
      check("t1_busy", 32'(o_busy), 32'd1);
      send(0, 60, 1'b1, 10);
      check("t1_gnt_released", 32'(o_gnt), 32'd0);
      n = 0;
      while (o_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t1_ifg_cycles", 32'(n), 32'd12);
      check("t1_frames", 32'(len_q.size()), 32'd1);
      check("t1_len", 32'(len_q[0]), 32'd60);
      check("t1_latency", 32'(start_q[0] - first_drive_cyc), 32'd1);
      check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

      // two persistent requesters alternate
      do_reset();
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      fork
         begin
            send(0, 20, 1'b0, 400);
            send(0, 20, 1'b1, 400);
         end
         send(1, 20, 1'b1, 400);
      join
      wait_idle("t2_idle");
      check("t2_frames", 32'(len_q.size()), 32'd3);
      check("t2_owner0", 32'(owner_q[0]), 32'd1);
      check("t2_owner1", 32'(owner_q[1]), 32'd2);
      check("t2_owner2", 32'(owner_q[2]), 32'd1);
      check("t2_gap0", 32'(gap_q[0]), 32'd14);
      check("t2_gap1", 32'(gap_q[1]), 32'd14);
      check("t2_len1", 32'(len_q[1]), 32'd20);

      // ch1 never raises en: start timeout, then pending ch0 wins
      do_reset();
      set_req(1, 1'b1);
      @(negedge clk);
      check("t3_gnt_ch1", 32'(o_gnt), 32'd2);
      set_req(0, 1'b1);
      n = 0;
      while (!o_timeout && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t3_timeout_cycles", 32'(n), 32'd64);
      check("t3_gnt_revoked", 32'(o_gnt), 32'd0);
      set_req(1, 1'b0);
      @(negedge clk);
      check("t3_timeout_pulse", 32'(o_timeout), 32'd0);
      check("t3_gnt_ch0", 32'(o_gnt), 32'd1);
      send(0, 10, 1'b1, 10);
      wait_idle("t3_idle");
      check("t3_tmo_count", 32'(tmo_n), 32'd1);
      check("t3_len", 32'(len_q[0]), 32'd10);

      // ch0 overruns: cut at MAX_LEN, then ch1 after a normal gap
      do_reset();
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      fork
         send(0, 2000, 1'b1, 10);
         send(1, 30, 1'b1, 3000);
      join
      wait_idle("t4_idle");
      check("t4_len_trunc", 32'(len_q[0]), 32'(MAX_LEN));
      check("t4_len_next", 32'(len_q[1]), 32'd30);
      check("t4_trunc_pulses", 32'(trunc_n), 32'd1);
      check("t4_gap", 32'(gap_q[0]), 32'd14);
      check("t4_owner_next", 32'(owner_q[1]), 32'd2);
      check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

      // ch1 withdraws in GRANT: no IFG, ch0 granted two cycles later
      do_reset();
      set_req(1, 1'b1);
      @(negedge clk);
      check("t5_gnt_ch1", 32'(o_gnt), 32'd2);
      set_req(1, 1'b0);
      set_req(0, 1'b1);
      @(negedge clk);
      check("t5_gnt_dropped", 32'(o_gnt), 32'd0);
      check("t5_no_ifg", 32'(o_busy), 32'd0);
      @(negedge clk);
      check("t5_gnt_ch0", 32'(o_gnt), 32'd1);
      send(0, 8, 1'b1, 10);
      wait_idle("t5_idle");
      check("t5_len", 32'(len_q[0]), 32'd8);

      // async reset in the middle of a frame
      do_reset();
      set_req(0, 1'b1);
      fork
         send(0, 40, 1'b1, 10);
         begin
            repeat (12) @(negedge clk);
            check("t6_pre_tx_en", 32'(o_tx_en), 32'd1);
            rst_n = 1'b0;
            #1;
            check("t6_rst_tx_en", 32'(o_tx_en), 32'd0);
            check("t6_rst_tx_data", 32'(o_tx_data), 32'd0);
            check("t6_rst_gnt", 32'(o_gnt), 32'd0);
            check("t6_rst_busy", 32'(o_busy), 32'd0);
         end
      join
      exp_q.delete();

`ifdef ETH_TX_ARB_STATS_EN
      // three clean ch0 frames, one truncated ch1 frame, then clear
      do_reset();
      set_req(0, 1'b1);
      send(0, 10, 1'b0, 10);
      send(0, 10, 1'b0, 400);
      send(0, 10, 1'b1, 400);
      wait_idle("t7_idle0");
      set_req(1, 1'b1);
      send(1, 2000, 1'b1, 10);
      wait_idle("t7_idle1");
      check("t7_cnt_ch0", 32'(o_frame_cnt[15:0]), 32'd3);
      check("t7_cnt_ch1", 32'(o_frame_cnt[31:16]), 32'd0);
      check("t7_trunc_pulses", 32'(trunc_n), 32'd1);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      check("t7_cnt_cleared", o_frame_cnt, 32'd0);
`endif

      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
